// File: rtl/chess_clock_sequencer.sv
// chess_clock_sequencer: turn sequencer and time keeper for a two-player chess clock.
// Optional feature macro CHESS_MOVE_COUNT_EN adds a 16-bit move counter in status[15:0].
module chess_clock_sequencer #(
  parameter int TICK_DIV = 5_000_000,
  parameter int TW       = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    clock_mode,
  input  logic [TW-1:0] init_time,
  input  logic [TW-1:0] inc_time,
  input  logic          load,
  input  logic          btn_a,
  input  logic          btn_b,
  input  logic          start_pause,
  output logic [TW-1:0] time_a,
  output logic [TW-1:0] time_b,
  output logic          active,
  output logic          running,
  output logic          flag_a,
  output logic          flag_b,
  output logic [31:0]   status
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN_A  = 3'd1,
    RUN_B  = 3'd2,
    PAUSED = 3'd3,
    FLAG   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] time_a_q, time_a_d;
  logic [TW-1:0] time_b_q, time_b_d;
  logic [TW-1:0] delay_q, delay_d;
  logic [TW-1:0] inc_q, inc_d;
  logic [1:0]    mode_q, mode_d;
  logic          active_q, active_d;
  logic          flag_a_q, flag_a_d;
  logic          flag_b_q, flag_b_d;
  logic [PW-1:0] presc_q, presc_d;

  logic          tick;
  logic          in_delay;
  logic          dec_tick;
  logic          hit_zero;
  logic          own_btn;
  logic [TW-1:0] cur_time;
  logic [TW-1:0] after_dec;
  logic [TW-1:0] after_inc;
  logic [TW-1:0] cur_next;
  logic [TW:0]   inc_sum;

`ifdef CHESS_MOVE_COUNT_EN
  logic [15:0]   move_cnt_q, move_cnt_d;
`endif

  // Time arithmetic for whichever clock is running: delay, decrement, then saturating increment.
  always_comb begin
    tick      = (presc_q == PRESC_LAST);
    cur_time  = (state_q == RUN_B) ? time_b_q : time_a_q;
    own_btn   = (state_q == RUN_B) ? btn_b : btn_a;
    in_delay  = tick && (mode_q == 2'd2) && (delay_q < inc_q);
    dec_tick  = tick && !in_delay;
    after_dec = (dec_tick && (cur_time != '0)) ? cur_time - TW'(1) : cur_time;
    hit_zero  = dec_tick && (after_dec == '0);
    inc_sum   = {1'b0, after_dec} + {1'b0, inc_q};
    if (mode_q == 2'd1) begin
      after_inc = inc_sum[TW] ? '1 : inc_sum[TW-1:0];
    end else begin
      after_inc = after_dec;
    end
  end

  always_comb begin
    state_d  = state_q;
    time_a_d = time_a_q;
    time_b_d = time_b_q;
    delay_d  = delay_q;
    inc_d    = inc_q;
    mode_d   = mode_q;
    active_d = active_q;
    flag_a_d = flag_a_q;
    flag_b_d = flag_b_q;
    cur_next = cur_time;
    presc_d  = tick ? '0 : presc_q + PW'(1);
`ifdef CHESS_MOVE_COUNT_EN
    move_cnt_d = move_cnt_q;
`endif

    if (load) begin
      state_d  = IDLE;
      time_a_d = init_time;
      time_b_d = init_time;
      inc_d    = inc_time;
      mode_d   = clock_mode;
      active_d = 1'b0;
      flag_a_d = 1'b0;
      flag_b_d = 1'b0;
      delay_d  = '0;
      presc_d  = '0;
`ifdef CHESS_MOVE_COUNT_EN
      move_cnt_d = 16'd0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (btn_a && !btn_b) begin
            state_d  = RUN_B;
            active_d = 1'b1;
            delay_d  = '0;
          end else if (btn_b && !btn_a) begin
            state_d  = RUN_A;
            active_d = 1'b0;
            delay_d  = '0;
          end
        end
        RUN_A, RUN_B: begin
          cur_next = after_dec;
          if (in_delay) begin
            delay_d = delay_q + TW'(1);
          end
          // Running out of time beats a same-cycle button press.
          if (hit_zero) begin
            state_d = FLAG;
            if (state_q == RUN_A) begin
              flag_a_d = 1'b1;
            end else begin
              flag_b_d = 1'b1;
            end
          end else if (own_btn) begin
            cur_next = after_inc;
            state_d  = (state_q == RUN_A) ? RUN_B : RUN_A;
            active_d = (state_q == RUN_A);
            delay_d  = '0;
`ifdef CHESS_MOVE_COUNT_EN
            move_cnt_d = move_cnt_q + 16'd1;
`endif
          end else if (start_pause) begin
            state_d = PAUSED;
          end
          if (state_q == RUN_A) begin
            time_a_d = cur_next;
          end else begin
            time_b_d = cur_next;
          end
        end
        PAUSED: begin
          if (start_pause) begin
            state_d = active_q ? RUN_B : RUN_A;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      time_a_q <= '0;
      time_b_q <= '0;
      delay_q  <= '0;
      inc_q    <= '0;
      mode_q   <= 2'd0;
      active_q <= 1'b0;
      flag_a_q <= 1'b0;
      flag_b_q <= 1'b0;
      presc_q  <= '0;
`ifdef CHESS_MOVE_COUNT_EN
      move_cnt_q <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      time_a_q <= time_a_d;
      time_b_q <= time_b_d;
      delay_q  <= delay_d;
      inc_q    <= inc_d;
      mode_q   <= mode_d;
      active_q <= active_d;
      flag_a_q <= flag_a_d;
      flag_b_q <= flag_b_d;
      presc_q  <= presc_d;
`ifdef CHESS_MOVE_COUNT_EN
      move_cnt_q <= move_cnt_d;
`endif
    end
  end

  assign time_a  = time_a_q;
  assign time_b  = time_b_q;
  assign active  = active_q;
  assign running = (state_q == RUN_A) || (state_q == RUN_B);
  assign flag_a  = flag_a_q;
  assign flag_b  = flag_b_q;
`ifdef CHESS_MOVE_COUNT_EN
  assign status  = {flag_b_q, flag_a_q, running, active_q, state_q, 9'b0, move_cnt_q};
`else
  assign status  = {flag_b_q, flag_a_q, running, active_q, state_q, 9'b0, 16'd0};
`endif

endmodule

// File: tb/tb_chess_clock_sequencer.sv
// tb_chess_clock_sequencer: scoreboard bench for the chess clock sequencer, run with a
// 4-cycle tick; honours CHESS_MOVE_COUNT_EN when predicting status[15:0].
module tb_chess_clock_sequencer;

  localparam int TD = 4;
`ifdef CHESS_MOVE_COUNT_EN
  localparam bit MC_EN = 1'b1;
`else
  localparam bit MC_EN = 1'b0;
`endif
  localparam logic [31:0] ALL   = 32'hFFFF_FFFF;
  localparam logic [31:0] NOACT = 32'hEFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  clock_mode = 2'd0;
  logic [15:0] init_time = 16'd0;
  logic [15:0] inc_time = 16'd0;
  logic        load = 1'b0;
  logic        btn_a = 1'b0;
  logic        btn_b = 1'b0;
  logic        start_pause = 1'b0;
  logic [15:0] time_a;
  logic [15:0] time_b;
  logic        active;
  logic        running;
  logic        flag_a;
  logic        flag_b;
  logic [31:0] status;

  typedef struct {
    string       name;
    logic [31:0] status;
    logic [31:0] mask;
    logic [15:0] ta;
    logic [15:0] tb;
  } exp_t;

  typedef struct {
    logic [31:0] status;
    logic [3:0]  bits;
    logic [15:0] ta;
    logic [15:0] tb;
  } obs_t;

  exp_t sb[$];
  obs_t ob[$];
  int   checks = 0;
  int   errors = 0;
  int   phase = 0;

  chess_clock_sequencer #(.TICK_DIV(TD), .TW(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clock_mode(clock_mode),
    .init_time(init_time),
    .inc_time(inc_time),
    .load(load),
    .btn_a(btn_a),
    .btn_b(btn_b),
    .start_pause(start_pause),
    .time_a(time_a),
    .time_b(time_b),
    .active(active),
    .running(running),
    .flag_a(flag_a),
    .flag_b(flag_b),
    .status(status)
  );

  always #5 clk = ~clk;

  // Reference prescaler phase: the edge taken while phase==TD-1 carries a time tick.
  always @(posedge clk) begin
    if (!reset_n || load) phase <= 0;
    else if (phase == TD - 1) phase <= 0;
    else phase <= phase + 1;
  end

  function automatic exp_t mk(input string n, input logic fb, input logic fa, input logic run,
                              input logic act, input logic [2:0] st, input logic [15:0] mv,
                              input logic [15:0] ta, input logic [15:0] tb, input logic [31:0] mask);
    exp_t e;
    e.name   = n;
    e.status = {fb, fa, run, act, st, 9'b0, (MC_EN ? mv : 16'd0)};
    e.mask   = mask;
    e.ta     = ta;
    e.tb     = tb;
    return e;
  endfunction

  function automatic obs_t snap();
    obs_t o;
    o.status = status;
    o.bits   = {flag_b, flag_a, running, active};
    o.ta     = time_a;
    o.tb     = time_b;
    return o;
  endfunction

  task automatic pulse(input logic a, input logic b, input logic sp);
    btn_a = a;
    btn_b = b;
    start_pause = sp;
    @(posedge clk);
    #1;
    btn_a = 1'b0;
    btn_b = 1'b0;
    start_pause = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] m, input logic [15:0] init, input logic [15:0] inc,
                         input logic b);
    clock_mode = m;
    init_time  = init;
    inc_time   = inc;
    load       = 1'b1;
    btn_b      = b;
    @(posedge clk);
    #1;
    load  = 1'b0;
    btn_b = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    int got = 0;
    int guard = 0;
    while (got < n && guard < 1000) begin
      if (phase == TD - 1) got++;
      pulse(1'b0, 1'b0, 1'b0);
      guard++;
    end
  endtask

  task automatic align_tick();
    int guard = 0;
    while (phase != TD - 1 && guard < 100) begin
      pulse(1'b0, 1'b0, 1'b0);
      guard++;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    obs_t o;
    reset_n = 1'b0;
    sb.push_back(mk("reset_state", 0, 0, 0, 0, 3'd0, 0, 0, 0, ALL));
    pulse(1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0);
    ob.push_back(snap());
    reset_n = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (ob.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s: no observation, expected status=%h", e.name, e.status);
      end else begin
        o = ob.pop_front();
        if (((o.status & e.mask) !== (e.status & e.mask)) ||
            ((o.bits & e.mask[31:28]) !== (e.status[31:28] & e.mask[31:28])) ||
            (o.ta !== e.ta) || (o.tb !== e.tb)) begin
          errors++;
          $display("[TB] FAIL %s: got status=%h fl/run/act=%b ta=%0d tb=%0d, expected status=%h ta=%0d tb=%0d",
                   e.name, o.status, o.bits, o.ta, o.tb, e.status & e.mask, e.ta, e.tb);
        end
      end
    end
  endtask

  task automatic test_sudden_death();
    exp_t e;
    obs_t o;
    sb.push_back(mk("sd_load", 0, 0, 0, 0, 3'd0, 0, 5, 5, NOACT));
    do_load(2'd0, 16'd5, 16'd0, 1'b0);
    ob.push_back(snap());
    sb.push_back(mk("sd_start", 0, 0, 1, 0, 3'd1, 0, 5, 5, ALL));
    pulse(1'b0, 1'b1, 1'b0);
    ob.push_back(snap());
    for (int k = 1; k <= 5; k++) begin
      if (k < 5) sb.push_back(mk($sformatf("sd_tick%0d", k), 0, 0, 1, 0, 3'd1, 0, 16'(5 - k), 5, ALL));
      else sb.push_back(mk("sd_flag", 0, 1, 0, 0, 3'd4, 0, 0, 5, ALL));
      run_ticks(1);
      ob.push_back(snap());
    end
    sb.push_back(mk("sd_frozen", 0, 1, 0, 0, 3'd4, 0, 0, 5, ALL));
    run_ticks(2);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    ob.push_back(snap());
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (ob.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s: no observation, expected status=%h", e.name, e.status);
      end else begin
        o = ob.pop_front();
        if (((o.status & e.mask) !== (e.status & e.mask)) ||
            ((o.bits & e.mask[31:28]) !== (e.status[31:28] & e.mask[31:28])) ||
            (o.ta !== e.ta) || (o.tb !== e.tb)) begin
          errors++;
          $display("[TB] FAIL %s: got status=%h fl/run/act=%b ta=%0d tb=%0d, expected status=%h ta=%0d tb=%0d",
                   e.name, o.status, o.bits, o.ta, o.tb, e.status & e.mask, e.ta, e.tb);
        end
      end
    end
  endtask

  task automatic test_fischer();
    exp_t e;
    obs_t o;
    sb.push_back(mk("fi_load", 0, 0, 0, 0, 3'd0, 0, 10, 10, NOACT));
    do_load(2'd1, 16'd10, 16'd3, 1'b0);
    ob.push_back(snap());
    sb.push_back(mk("fi_switch", 0, 0, 1, 1, 3'd2, 1, 11, 10, ALL));
    pulse(1'b0, 1'b1, 1'b0);
    run_ticks(2);
    pulse(1'b1, 1'b0, 1'b0);
    ob.push_back(snap());
    sb.push_back(mk("fi_b_tick", 0, 0, 1, 1, 3'd2, 1, 11, 9, ALL));
    run_ticks(1);
    ob.push_back(snap());
    sb.push_back(mk("fi_sat_load", 0, 0, 0, 0, 3'd0, 0, 16'hFFFE, 16'hFFFE, NOACT));
    do_load(2'd1, 16'hFFFE, 16'd5, 1'b0);
    ob.push_back(snap());
    pulse(1'b0, 1'b1, 1'b0);
    sb.push_back(mk("fi_sat_a", 0, 0, 1, 1, 3'd2, 1, 16'hFFFF, 16'hFFFE, ALL));
    pulse(1'b1, 1'b0, 1'b0);
    ob.push_back(snap());
    sb.push_back(mk("fi_sat_b", 0, 0, 1, 0, 3'd1, 2, 16'hFFFF, 16'hFFFF, ALL));
    pulse(1'b0, 1'b1, 1'b0);
    ob.push_back(snap());
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (ob.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s: no observation, expected status=%h", e.name, e.status);
      end else begin
        o = ob.pop_front();
        if (((o.status & e.mask) !== (e.status & e.mask)) ||
            ((o.bits & e.mask[31:28]) !== (e.status[31:28] & e.mask[31:28])) ||
            (o.ta !== e.ta) || (o.tb !== e.tb)) begin
          errors++;
          $display("[TB] FAIL %s: got status=%h fl/run/act=%b ta=%0d tb=%0d, expected status=%h ta=%0d tb=%0d",
                   e.name, o.status, o.bits, o.ta, o.tb, e.status & e.mask, e.ta, e.tb);
        end
      end
    end
  endtask

  task automatic test_delay();
    exp_t e;
    obs_t o;
    do_load(2'd2, 16'd20, 16'd2, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    sb.push_back(mk("dl_a_4ticks", 0, 0, 1, 0, 3'd1, 0, 18, 20, ALL));
    run_ticks(4);
    ob.push_back(snap());
    sb.push_back(mk("dl_to_b", 0, 0, 1, 1, 3'd2, 1, 18, 20, ALL));
    pulse(1'b1, 1'b0, 1'b0);
    ob.push_back(snap());
    sb.push_back(mk("dl_b_free", 0, 0, 1, 1, 3'd2, 1, 18, 20, ALL));
    run_ticks(2);
    ob.push_back(snap());
    sb.push_back(mk("dl_b_dec", 0, 0, 1, 1, 3'd2, 1, 18, 19, ALL));
    run_ticks(1);
    ob.push_back(snap());
    pulse(1'b0, 1'b1, 1'b0);
    sb.push_back(mk("dl_a_restart", 0, 0, 1, 0, 3'd1, 2, 18, 19, ALL));
    run_ticks(2);
    ob.push_back(snap());
    sb.push_back(mk("dl_a_dec", 0, 0, 1, 0, 3'd1, 2, 17, 19, ALL));
    run_ticks(1);
    ob.push_back(snap());
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (ob.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s: no observation, expected status=%h", e.name, e.status);
      end else begin
        o = ob.pop_front();
        if (((o.status & e.mask) !== (e.status & e.mask)) ||
            ((o.bits & e.mask[31:28]) !== (e.status[31:28] & e.mask[31:28])) ||
            (o.ta !== e.ta) || (o.tb !== e.tb)) begin
          errors++;
          $display("[TB] FAIL %s: got status=%h fl/run/act=%b ta=%0d tb=%0d, expected status=%h ta=%0d tb=%0d",
                   e.name, o.status, o.bits, o.ta, o.tb, e.status & e.mask, e.ta, e.tb);
        end
      end
    end
  endtask

  task automatic test_pause();
    exp_t e;
    obs_t o;
    do_load(2'd0, 16'd30, 16'd0, 1'b0);
    sb.push_back(mk("pa_idle_to_b", 0, 0, 1, 1, 3'd2, 0, 30, 30, ALL));
    pulse(1'b1, 1'b0, 1'b0);
    ob.push_back(snap());
    run_ticks(1);
    sb.push_back(mk("pa_paused", 0, 0, 0, 1, 3'd3, 0, 30, 29, ALL));
    pulse(1'b0, 1'b0, 1'b1);
    ob.push_back(snap());
    sb.push_back(mk("pa_ignored", 0, 0, 0, 1, 3'd3, 0, 30, 29, ALL));
    run_ticks(3);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    ob.push_back(snap());
    sb.push_back(mk("pa_resume", 0, 0, 1, 1, 3'd2, 0, 30, 29, ALL));
    pulse(1'b0, 1'b0, 1'b1);
    ob.push_back(snap());
    sb.push_back(mk("pa_resume_tick", 0, 0, 1, 1, 3'd2, 0, 30, 28, ALL));
    run_ticks(1);
    ob.push_back(snap());
    sb.push_back(mk("pa_btn_beats_pause", 0, 0, 1, 0, 3'd1, 1, 30, 28, ALL));
    pulse(1'b0, 1'b1, 1'b1);
    ob.push_back(snap());
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (ob.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s: no observation, expected status=%h", e.name, e.status);
      end else begin
        o = ob.pop_front();
        if (((o.status & e.mask) !== (e.status & e.mask)) ||
            ((o.bits & e.mask[31:28]) !== (e.status[31:28] & e.mask[31:28])) ||
            (o.ta !== e.ta) || (o.tb !== e.tb)) begin
          errors++;
          $display("[TB] FAIL %s: got status=%h fl/run/act=%b ta=%0d tb=%0d, expected status=%h ta=%0d tb=%0d",
                   e.name, o.status, o.bits, o.ta, o.tb, e.status & e.mask, e.ta, e.tb);
        end
      end
    end
  endtask

  task automatic test_flag_race();
    exp_t e;
    obs_t o;
    do_load(2'd1, 16'd10, 16'd3, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    align_tick();
    sb.push_back(mk("fr_tick_and_btn", 0, 0, 1, 1, 3'd2, 1, 12, 10, ALL));
    pulse(1'b1, 1'b0, 1'b0);
    ob.push_back(snap());
    sb.push_back(mk("fr_load1", 0, 0, 0, 0, 3'd0, 0, 1, 1, NOACT));
    do_load(2'd1, 16'd1, 16'd5, 1'b0);
    ob.push_back(snap());
    pulse(1'b0, 1'b1, 1'b0);
    align_tick();
    sb.push_back(mk("fr_flag_wins", 0, 1, 0, 0, 3'd4, 0, 0, 1, ALL));
    pulse(1'b1, 1'b0, 1'b0);
    ob.push_back(snap());
    sb.push_back(mk("fr_flag_frozen", 0, 1, 0, 0, 3'd4, 0, 0, 1, ALL));
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    run_ticks(1);
    ob.push_back(snap());
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (ob.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s: no observation, expected status=%h", e.name, e.status);
      end else begin
        o = ob.pop_front();
        if (((o.status & e.mask) !== (e.status & e.mask)) ||
            ((o.bits & e.mask[31:28]) !== (e.status[31:28] & e.mask[31:28])) ||
            (o.ta !== e.ta) || (o.tb !== e.tb)) begin
          errors++;
          $display("[TB] FAIL %s: got status=%h fl/run/act=%b ta=%0d tb=%0d, expected status=%h ta=%0d tb=%0d",
                   e.name, o.status, o.bits, o.ta, o.tb, e.status & e.mask, e.ta, e.tb);
        end
      end
    end
  endtask

  task automatic test_load_reset();
    exp_t e;
    obs_t o;
    do_load(2'd0, 16'd50, 16'd0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    sb.push_back(mk("lr_run_b", 0, 0, 1, 1, 3'd2, 0, 50, 49, ALL));
    run_ticks(1);
    ob.push_back(snap());
    sb.push_back(mk("lr_load_priority", 0, 0, 0, 0, 3'd0, 0, 100, 100, NOACT));
    do_load(2'd0, 16'd100, 16'd0, 1'b1);
    ob.push_back(snap());
    sb.push_back(mk("lr_zero_idle", 0, 0, 0, 0, 3'd0, 0, 0, 0, NOACT));
    do_load(2'd0, 16'd0, 16'd0, 1'b0);
    ob.push_back(snap());
    pulse(1'b1, 1'b0, 1'b0);
    sb.push_back(mk("lr_zero_flag_b", 1, 0, 0, 1, 3'd4, 0, 0, 0, ALL));
    run_ticks(1);
    ob.push_back(snap());
    do_load(2'd3, 16'd10, 16'd4, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    sb.push_back(mk("lr_mode3_no_inc", 0, 0, 1, 1, 3'd2, 1, 10, 10, ALL));
    pulse(1'b1, 1'b0, 1'b0);
    ob.push_back(snap());
    sb.push_back(mk("lr_reset", 0, 0, 0, 0, 3'd0, 0, 0, 0, ALL));
    reset_n = 1'b0;
    pulse(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    ob.push_back(snap());
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (ob.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s: no observation, expected status=%h", e.name, e.status);
      end else begin
        o = ob.pop_front();
        if (((o.status & e.mask) !== (e.status & e.mask)) ||
            ((o.bits & e.mask[31:28]) !== (e.status[31:28] & e.mask[31:28])) ||
            (o.ta !== e.ta) || (o.tb !== e.tb)) begin
          errors++;
          $display("[TB] FAIL %s: got status=%h fl/run/act=%b ta=%0d tb=%0d, expected status=%h ta=%0d tb=%0d",
                   e.name, o.status, o.bits, o.ta, o.tb, e.status & e.mask, e.ta, e.tb);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_sudden_death();
    test_fischer();
    test_delay();
    test_pause();
    test_flag_race();
    test_load_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
